// File: rtl/diffeq_pkg.sv
// Shared types and sizes for the diffeq solver job driver.
// The optional iteration cap is enabled with DIFFEQ_DRV_TIMEOUT_EN.
package diffeq_pkg;
  localparam int DATA_W       = 32;
  localparam int ITER_W       = 16;
  localparam int MAX_ITER_DEF = 65535;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    DONE
  } state_t;
endpackage

// File: rtl/diffeq_iter_tracker.sv
// Shadow copy of the solver's x register plus an iteration counter, kept in lockstep.
// With DIFFEQ_DRV_TIMEOUT_EN defined, flags when the count reaches CAP with x still below a.
module diffeq_iter_tracker
  import diffeq_pkg::*;
#(
  parameter int CAP = MAX_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              step,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] dx,
  output logic              below,
  output logic              timeout
);
  logic [DATA_W-1:0] x_sh;
  logic [ITER_W-1:0] iter;

  if (CAP < 0 || CAP > (2**ITER_W) - 1) begin : g_cap_range
    $error("diffeq_iter_tracker: CAP does not fit in ITER_W bits");
  end

  // The adder wraps mod 2^DATA_W, exactly like the solver's own x update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_sh <= '0;
      iter <= '0;
    end else if (init) begin
      x_sh <= x0;
      iter <= '0;
    end else if (step) begin
      x_sh <= x_sh + dx;
      iter <= iter + 1'b1;
    end
  end

  assign below = (x_sh < a);

`ifdef DIFFEQ_DRV_TIMEOUT_EN
  localparam logic [ITER_W-1:0] CAP_V = ITER_W'(CAP);
  assign timeout = below && (iter == CAP_V);
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: rtl/diffeq_job_driver.sv
// Initiator for the diffeq solver: accepts a job, runs the solver in lockstep, returns results.
// Define DIFFEQ_DRV_TIMEOUT_EN to abort jobs that exceed MAX_ITER iterations.
module diffeq_job_driver
  import diffeq_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [DATA_W-1:0] job_x,
  input  logic [DATA_W-1:0] job_y,
  input  logic [DATA_W-1:0] job_u,
  input  logic [DATA_W-1:0] job_a,
  input  logic [DATA_W-1:0] job_dx,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_x,
  output logic [DATA_W-1:0] res_y,
  output logic [DATA_W-1:0] res_u,
  output logic              res_err,
  output logic              busy,
  output logic              sol_reset,
  output logic [DATA_W-1:0] sol_xin,
  output logic [DATA_W-1:0] sol_yin,
  output logic [DATA_W-1:0] sol_uin,
  output logic [DATA_W-1:0] sol_a,
  output logic [DATA_W-1:0] sol_dx,
  input  logic [DATA_W-1:0] sol_xout,
  input  logic [DATA_W-1:0] sol_yout,
  input  logic [DATA_W-1:0] sol_uout
);
  state_t state, state_nxt;
  logic   init, step, do_cap, do_abort, do_rel;
  logic   below, timeout;

  diffeq_iter_tracker #(.CAP(MAX_ITER)) u_trk (
    .clk    (clk),
    .rst    (reset),
    .init   (init),
    .step   (step),
    .x0     (job_x),
    .a      (sol_a),
    .dx     (sol_dx),
    .below  (below),
    .timeout(timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    init      = 1'b0;
    step      = 1'b0;
    do_cap    = 1'b0;
    do_abort  = 1'b0;
    do_rel    = 1'b0;
    unique case (state)
      IDLE: if (job_valid) begin
        init      = 1'b1;
        state_nxt = LOAD;
      end
      // One cycle while the solver loads its operand registers.
      LOAD: state_nxt = RUN;
      RUN: begin
        if (timeout) begin
          do_abort  = 1'b1;
          state_nxt = DONE;
        end else if (below) begin
          step = 1'b1;
        end else begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        do_cap    = 1'b1;
        state_nxt = DONE;
      end
      // Returning to IDLE here means the next job is taken one cycle later at the earliest.
      DONE: if (res_ready) begin
        do_rel    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign job_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sol_reset <= 1'b1;
      sol_xin   <= '0;
      sol_yin   <= '0;
      sol_uin   <= '0;
      sol_a     <= '0;
      sol_dx    <= '0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_x     <= '0;
      res_y     <= '0;
      res_u     <= '0;
    end else begin
      if (init) begin
        sol_xin   <= job_x;
        sol_yin   <= job_y;
        sol_uin   <= job_u;
        sol_a     <= job_a;
        sol_dx    <= job_dx;
        sol_reset <= 1'b0;
      end
      if (do_cap) begin
        res_x     <= sol_xout;
        res_y     <= sol_yout;
        res_u     <= sol_uout;
        res_err   <= 1'b0;
        res_valid <= 1'b1;
        sol_reset <= 1'b1;
      end
      if (do_abort) begin
        res_x     <= '0;
        res_y     <= '0;
        res_u     <= '0;
        res_err   <= 1'b1;
        res_valid <= 1'b1;
        sol_reset <= 1'b1;
      end
      if (do_rel) res_valid <= 1'b0;
    end
  end
endmodule

// File: doc/diffeq_job_driver.md
DIFFEQ_JOB_DRIVER -- requirements
Module: diffeq_job_driver

Interface
REQ-001 SHALL have parameter: MAX_ITER, 65535, iteration cap (used only when timeout is compiled in).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- job_valid / job_ready  in / out  1  job-side handshake.
- job_x, job_y, job_u, job_a, job_dx  in  32  job operands.
- res_valid / res_ready  out / in  1  result-side handshake.
- res_x, res_y, res_u  out  32  result values.
- res_err  out  1  result aborted.
- busy  out  1  job in flight.
- sol_reset  out  1  drives the solver's reset.
- sol_xin, sol_yin, sol_uin, sol_a, sol_dx  out  32  drive the solver's inputs.
- sol_xout, sol_yout, sol_uout  in  32  solver results.

Function
REQ-003 SHALL be the initiator for the diffeq solver: it accepts one job, runs the solver, and returns its results on a valid/ready result port.
REQ-004 SHALL implement states IDLE, LOAD, RUN, CAPTURE, DONE; job_ready=1 only in IDLE; busy=1 in every state except IDLE.
REQ-005 IDLE, on job_valid&&job_ready:
- latch the operands into sol_* registers.
- set shadow x_sh=job_x and iter=0.
- set sol_reset<=0.
- go to LOAD.
REQ-006 LOAD SHALL last exactly one cycle, mirroring the solver's load cycle, then go to RUN.
REQ-007 RUN, each edge: if x_sh<sol_a (unsigned), x_sh<=x_sh+sol_dx (mod 2^32) and iter<=iter+1; else go to CAPTURE.
REQ-008 CAPTURE SHALL do the following, then go to DONE:
- sample sol_xout/sol_yout/sol_uout into res_*.
- set res_err<=0 and res_valid<=1.
- set sol_reset<=1.
REQ-009 DONE SHALL hold res_* and res_valid stable until res_ready=1, then clear res_valid and go to IDLE; no new job SHALL be accepted in that same cycle.
REQ-010 Latency: acceptance at edge 0 SHALL give res_valid=1 after edge N+3, where N = number of RUN iterations; job_x>=job_a gives N=0.
REQ-011 The x_sh adder SHALL wrap mod 2^32 exactly as the solver does, so lockstep holds across overflow.
REQ-012 sol_* operand outputs SHALL stay constant from acceptance until return to IDLE.

Reset
REQ-013 Reset SHALL force, asynchronously:
- state=IDLE and sol_reset=1.
- res_valid=0, res_err=0, res_x=res_y=res_u=0.
- sol_* operands=0, x_sh=0, iter=0, busy=0.
REQ-014 Reset asserted mid-job SHALL abandon the job with no result produced; operation resumes in IDLE.

Configuration
REQ-015 Macro DIFFEQ_DRV_TIMEOUT_EN, when defined: in RUN, if iter==MAX_ITER and x_sh<sol_a:
- set sol_reset<=1.
- set res_x=res_y=res_u=0, res_err<=1, res_valid<=1.
- go to DONE.
REQ-016 Without DIFFEQ_DRV_TIMEOUT_EN: no cap and res_err tied 0, so DX=0 with X<A hangs by design; iter is a 16-bit free-running counter.

Structure
REQ-017 A shared package diffeq_pkg SHALL hold:
- the state enum.
- DATA_W=32 and ITER_W=16.
- the MAX_ITER default.
REQ-018 The shadow x/iteration tracker (x_sh, iter, compare, adder) SHALL be sub-module diffeq_iter_tracker; the FSM and handshakes stay in the top level.

Verification
REQ-019 Bench SHALL instantiate diffeq_job_driver with the solver and cover:
- Job X=0,Y=0,U=1,A=1,DX=1, res_ready=1 -> res_valid after edge 4; res=(1,1,1), res_err=0.
- Job X=0,A=4,DX=1 -> N=4, res_valid after edge 7, res_x=4; job_ready=0 throughout.
- Job X=5,A=3 -> N=0, res_valid after edge 3, res_x=5, res_y=Y, res_u=U.
- res_ready held low 10 cycles in DONE -> res_* stable, job_valid ignored; first accept one cycle after the handshake.
- With DIFFEQ_DRV_TIMEOUT_EN, MAX_ITER=8, job X=0,A=1,DX=0 -> res_err=1, res_*=0, sol_reset=1; next job completes normally.
- Reset pulsed during RUN -> sol_reset=1, busy=0 and res_valid=0 immediately; the following job gives correct results.
